sreg_stream_feeder: RTL and testbench

Upstream pacing stage for the static multi-bit shift register: ports ce and si connect directly to the register's ce/si.
- Accepts WIDTH-bit words over a valid/ready stream into a small FIFO.
- Issues them to the register as single-cycle ce strokes with si, spaced by a programmable minimum gap.
- On request, flushes the register with DEPTH zero-valued strokes so its old contents drain out of so.

---
 rtl/sreg_stream_feeder.sv | 145 ++++++++++++++
 tb/tb_sreg_stream_feeder.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sreg_stream_feeder.sv
// Paces a valid/ready word stream into single-cycle ce/si strokes for a static shift
// register, enforcing a minimum inter-stroke gap and offering an on-demand zero flush.
module sreg_stream_feeder #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned GAP        = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [WIDTH-1:0]                s_data,
    input  logic                            flush_req,
    output logic                            ce,
    output logic [WIDTH-1:0]                si,
    output logic                            flush_done,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fill
);
    localparam int unsigned FILL_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned HO_W   = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr, wr_ptr_d;
    logic [0:0]        state, state_d;
    logic [HO_W-1:0]   holdoff, holdoff_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              flush_pending, flush_pending_d;
    logic [FILL_W-1:0] fill_d;
    logic [WIDTH-1:0]  si_d;
    logic              ce_d;
    logic              flush_done_d;
    logic              s_ready_d;
    logic              busy_d;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              holdoff_zero;

    assign push         = s_valid && s_ready;
    assign fifo_empty   = (fill == '0);
    assign holdoff_zero = (holdoff == '0);

    // FIFO storage; pointers wrap naturally since FIFO_DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // Next-state, stroke issue and registered-output computation
    always_comb begin
        state_d         = state;
        cnt_d           = cnt;
        flush_pending_d = flush_pending;
        holdoff_d       = holdoff_zero ? '0 : holdoff - HO_W'(1);
        ce_d            = 1'b0;
        si_d            = si;
        flush_done_d    = 1'b0;
        pop             = 1'b0;

        if (flush_req && !flush_pending && state != ST_FLUSH) begin
            flush_pending_d = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (holdoff_zero && !fifo_empty) begin
                    pop       = 1'b1;
                    ce_d      = 1'b1;
                    si_d      = mem[rd_ptr];
                    holdoff_d = HO_W'(GAP);
                end else if (flush_pending && fifo_empty && holdoff_zero) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end
            end
            ST_FLUSH: begin
                if (holdoff_zero) begin
                    if (cnt == CNT_W'(DEPTH)) begin
                        flush_done_d    = 1'b1;
                        flush_pending_d = 1'b0;
                        state_d         = ST_IDLE;
                    end else begin
                        ce_d      = 1'b1;
                        si_d      = '0;
                        cnt_d     = cnt + CNT_W'(1);
                        holdoff_d = HO_W'(GAP);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rd_ptr_d = rd_ptr + PTR_W'(pop);
        wr_ptr_d = wr_ptr + PTR_W'(push);
        fill_d   = fill + FILL_W'(push) - FILL_W'(pop);

        // Readiness reflects the post-edge state, so a flush request closes the input next edge
        s_ready_d = (fill_d != FILL_W'(FIFO_DEPTH)) && !flush_pending_d && (state_d != ST_FLUSH);
        busy_d    = (fill_d != '0) || (holdoff_d != '0) || ce_d || flush_pending_d
                    || (state_d == ST_FLUSH);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            flush_pending <= 1'b0;
            holdoff       <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            fill          <= '0;
            ce            <= 1'b0;
            si            <= '0;
            flush_done    <= 1'b0;
            s_ready       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            flush_pending <= flush_pending_d;
            holdoff       <= holdoff_d;
            rd_ptr        <= rd_ptr_d;
            wr_ptr        <= wr_ptr_d;
            fill          <= fill_d;
            ce            <= ce_d;
            si            <= si_d;
            flush_done    <= flush_done_d;
            s_ready       <= s_ready_d;
            busy          <= busy_d;
        end
    end

endmodule

// File: tb/tb_sreg_stream_feeder.sv
// Bench for sreg_stream_feeder: a GAP=3 and a GAP=0 instance checked against a
// timestamp-based reference model of the stroke pacing and flush rules.
module tb_sreg_stream_feeder;
    localparam int unsigned W   = 4;
    localparam int unsigned DEP = 4;
    localparam int unsigned FD  = 4;
    localparam int unsigned FW  = $clog2(FD + 1);
    localparam int unsigned VW  = W + FW + 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic [W-1:0]  s_data;
    logic          flush_req;
    logic          sel;

    logic          rdy3, ce3, done3, busy3;
    logic [W-1:0]  si3;
    logic [FW-1:0] fill3;
    logic          rdy0, ce0, done0, busy0;
    logic [W-1:0]  si0;
    logic [FW-1:0] fill0;

    logic          o_ce, o_done, o_ready, o_busy;
    logic [W-1:0]  o_si;
    logic [FW-1:0] o_fill;
    logic [VW-1:0] obs_vec;
    logic [VW-1:0] exp_vec;

    int total;
    int bad;

    // Reference model state
    int            m_gap;
    int            m_cyc;
    int            m_last;
    int            m_zeros;
    logic [W-1:0]  m_q[$];
    logic          m_pend, m_flush, m_ce, m_done, m_ready, m_busy;
    logic [W-1:0]  m_si;

    sreg_stream_feeder #(.WIDTH(W), .DEPTH(DEP), .GAP(3), .FIFO_DEPTH(FD)) dut3 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy3), .s_data(s_data),
        .flush_req(flush_req), .ce(ce3), .si(si3), .flush_done(done3), .busy(busy3),
        .fill(fill3)
    );

    sreg_stream_feeder #(.WIDTH(W), .DEPTH(DEP), .GAP(0), .FIFO_DEPTH(FD)) dut0 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy0), .s_data(s_data),
        .flush_req(flush_req), .ce(ce0), .si(si0), .flush_done(done0), .busy(busy0),
        .fill(fill0)
    );

    assign o_ce    = sel ? ce0   : ce3;
    assign o_si    = sel ? si0   : si3;
    assign o_done  = sel ? done0 : done3;
    assign o_ready = sel ? rdy0  : rdy3;
    assign o_busy  = sel ? busy0 : busy3;
    assign o_fill  = sel ? fill0 : fill3;
    assign obs_vec = {o_ce, o_si, o_done, o_ready, o_busy, o_fill};

    always #5 clk = ~clk;

    // Strokes are legal once GAP+1 cycles have elapsed since the previous stroke edge
    task automatic model_step();
        logic allowed;
        logic new_pend;
        logic acc;
        m_cyc++;
        acc = s_valid && m_ready;
        if (rst) begin
            m_q.delete();
            m_pend  = 1'b0;
            m_flush = 1'b0;
            m_ce    = 1'b0;
            m_si    = '0;
            m_done  = 1'b0;
            m_ready = 1'b0;
            m_busy  = 1'b0;
            m_last  = -1000;
            m_zeros = 0;
        end else begin
            allowed  = (m_cyc - m_last) >= m_gap + 1;
            new_pend = m_pend;
            if (flush_req && !m_pend && !m_flush) new_pend = 1'b1;
            m_ce   = 1'b0;
            m_done = 1'b0;
            if (!m_flush) begin
                if (allowed && m_q.size() > 0) begin
                    m_ce   = 1'b1;
                    m_si   = m_q.pop_front();
                    m_last = m_cyc;
                end else if (m_pend && m_q.size() == 0 && allowed) begin
                    m_flush = 1'b1;
                    m_zeros = 0;
                end
            end else if (allowed) begin
                if (m_zeros == int'(DEP)) begin
                    m_done   = 1'b1;
                    new_pend = 1'b0;
                    m_flush  = 1'b0;
                end else begin
                    m_ce   = 1'b1;
                    m_si   = '0;
                    m_zeros++;
                    m_last = m_cyc;
                end
            end
            if (acc) m_q.push_back(s_data);
            m_pend  = new_pend;
            m_ready = (m_q.size() < int'(FD)) && !m_pend && !m_flush;
            m_busy  = (m_q.size() != 0) || ((m_cyc - m_last) < m_gap) || m_ce || m_pend || m_flush;
        end
        exp_vec = {m_ce, m_si, m_done, m_ready, m_busy, FW'(m_q.size())};
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b1; s_data = 4'h5; flush_req = 1'b0;
        repeat (2) begin
            tick();
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL reset_vec cyc=%0d got=%h exp=%h", m_cyc, obs_vec, exp_vec);
            end
            total++;
            if ({o_ce, o_si, o_busy, o_fill, o_ready} !== '0) begin
                bad++; $display("FAIL reset_zero ce=%b si=%h busy=%b fill=%0d ready=%b",
                                o_ce, o_si, o_busy, o_fill, o_ready);
            end
        end
        rst = 1'b0; s_valid = 1'b0;
        tick();
        total++;
        if (o_ready !== 1'b1 || obs_vec !== exp_vec) begin
            bad++; $display("FAIL reset_release ready=%b got=%h exp=%h", o_ready, obs_vec, exp_vec);
        end
    endtask

    task automatic test_single_word();
        int e;
        int sc[$];
        logic [W-1:0] sv[$];
        e = 0;
        for (int i = 0; i < 12; i++) begin
            s_valid = (i < 2);
            s_data  = (i == 0) ? 4'hA : 4'h3;
            tick();
            if (i == 0) e = m_cyc;
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL single_vec cyc=%0d got=%h exp=%h", m_cyc, obs_vec, exp_vec);
            end
            if (o_ce === 1'b1) begin sc.push_back(m_cyc); sv.push_back(o_si); end
        end
        s_valid = 1'b0;
        total++;
        if (sc.size() != 2 || sc[0] != e + 1 || sc[1] != e + 5 || sv[0] !== 4'hA || sv[1] !== 4'h3) begin
            bad++; $display("FAIL single_timing strokes=%0d first=%0d second=%0d want=%0d,%0d",
                            sc.size(), sc.size() > 0 ? sc[0] - e : -1, sc.size() > 1 ? sc[1] - e : -1, 1, 5);
        end
    endtask

    task automatic test_burst();
        int nxt;
        int maxfill;
        logic acc;
        int sc[$];
        logic [W-1:0] sv[$];
        logic ok;
        nxt = 1; maxfill = 0;
        for (int i = 0; i < 40; i++) begin
            s_valid = (nxt <= 6);
            s_data  = W'(nxt);
            acc     = s_valid && m_ready;
            tick();
            if (acc) nxt++;
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL burst_vec cyc=%0d got=%h exp=%h", m_cyc, obs_vec, exp_vec);
            end
            if (int'(o_fill) > maxfill) maxfill = int'(o_fill);
            if (o_ce === 1'b1) begin sc.push_back(m_cyc); sv.push_back(o_si); end
        end
        s_valid = 1'b0;
        ok = (sc.size() == 6);
        for (int k = 0; k < sc.size() && k < 6; k++) begin
            if (sv[k] !== W'(k + 1)) ok = 1'b0;
            if (k > 0 && sc[k] - sc[k-1] != 4) ok = 1'b0;
        end
        total++;
        if (!ok || maxfill > 4) begin
            bad++; $display("FAIL burst_order strokes=%0d maxfill=%0d want 6 strokes period 4 fill<=4",
                            sc.size(), maxfill);
        end
    endtask

    task automatic test_flush();
        int zc[$];
        int dc[$];
        logic ok;
        for (int i = 0; i < 50; i++) begin
            s_valid   = (i < 2);
            s_data    = (i == 0) ? 4'hB : 4'hC;
            flush_req = (i == 2);
            tick();
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL flush_vec cyc=%0d got=%h exp=%h", m_cyc, obs_vec, exp_vec);
            end
            if (i == 2) begin
                total++;
                if (o_ready !== 1'b0) begin
                    bad++; $display("FAIL flush_ready_drop ready=%b want 0", o_ready);
                end
            end
            if (o_ce === 1'b1 && o_si === '0) zc.push_back(m_cyc);
            if (o_done === 1'b1) dc.push_back(m_cyc);
        end
        s_valid = 1'b0; flush_req = 1'b0;
        ok = (zc.size() == int'(DEP)) && (dc.size() == 1);
        for (int k = 1; k < zc.size(); k++) if (zc[k] - zc[k-1] != 4) ok = 1'b0;
        if (ok && dc[0] - zc[zc.size()-1] != 4) ok = 1'b0;
        total++;
        if (!ok) begin
            bad++; $display("FAIL flush_seq zeros=%0d dones=%0d want %0d zeros, 1 done 4 cycles after",
                            zc.size(), dc.size(), DEP);
        end
        total++;
        if (o_busy !== 1'b0 || o_ready !== 1'b1) begin
            bad++; $display("FAIL flush_idle busy=%b ready=%b want 0,1", o_busy, o_ready);
        end
    endtask

    task automatic test_reset_mid_flush();
        int nz;
        int nd;
        int acc_cyc;
        int sc[$];
        logic [W-1:0] sv[$];
        nz = 0; nd = 0; acc_cyc = 0;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        for (int i = 0; i < 40 && nz < 2; i++) begin
            tick();
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL midrst_vec cyc=%0d got=%h exp=%h", m_cyc, obs_vec, exp_vec);
            end
            if (o_ce === 1'b1 && o_si === '0) nz++;
        end
        total++;
        if (nz != 2) begin
            bad++; $display("FAIL midrst_timeout zero_strokes=%0d want 2", nz);
        end
        rst = 1'b1;
        tick();
        total++;
        if (o_ce !== 1'b0 || o_si !== '0 || obs_vec !== exp_vec) begin
            bad++; $display("FAIL midrst_clear ce=%b si=%h got=%h exp=%h", o_ce, o_si, obs_vec, exp_vec);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            s_valid = (i == 1);
            s_data  = 4'h9;
            tick();
            if (i == 1) acc_cyc = m_cyc;
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL midrst_after cyc=%0d got=%h exp=%h", m_cyc, obs_vec, exp_vec);
            end
            if (o_done === 1'b1) nd++;
            if (o_ce === 1'b1) begin sc.push_back(m_cyc); sv.push_back(o_si); end
        end
        s_valid = 1'b0;
        total++;
        if (nd != 0 || sc.size() != 1 || sc[0] != acc_cyc + 1 || sv[0] !== 4'h9) begin
            bad++; $display("FAIL midrst_resume dones=%0d strokes=%0d want 0 dones, 1 stroke of 9",
                            nd, sc.size());
        end
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n + 60; i++) begin
            if (i < n) begin
                s_valid   = ($urandom_range(0, 9) < 6);
                s_data    = W'($urandom);
                flush_req = ($urandom_range(0, 39) == 0);
                rst       = ($urandom_range(0, 199) == 0);
            end else begin
                s_valid = 1'b0; flush_req = 1'b0; rst = 1'b0;
            end
            tick();
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL random_vec gap=%0d cyc=%0d got=%h exp=%h", m_gap, m_cyc, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_gap0();
        int e;
        int sc[$];
        logic [W-1:0] sv[$];
        e = 0;
        sel = 1'b1; m_gap = 0;
        rst = 1'b1; s_valid = 1'b0; flush_req = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            s_valid = (i < 3);
            s_data  = W'(7 + i);
            tick();
            if (i == 0) e = m_cyc;
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL gap0_vec cyc=%0d got=%h exp=%h", m_cyc, obs_vec, exp_vec);
            end
            if (o_ce === 1'b1) begin sc.push_back(m_cyc); sv.push_back(o_si); end
        end
        s_valid = 1'b0;
        total++;
        if (sc.size() != 3 || sc[0] != e + 1 || sc[1] != e + 2 || sc[2] != e + 3
            || sv[0] !== 4'h7 || sv[1] !== 4'h8 || sv[2] !== 4'h9) begin
            bad++; $display("FAIL gap0_b2b strokes=%0d want 3 consecutive strokes 7,8,9", sc.size());
        end
        test_random(300);
    endtask

    initial begin
        total = 0; bad = 0;
        sel = 1'b0; m_gap = 3;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; flush_req = 1'b0;
        m_cyc = 0; m_last = -1000; m_zeros = 0;
        m_pend = 1'b0; m_flush = 1'b0; m_ce = 1'b0; m_done = 1'b0;
        m_ready = 1'b0; m_busy = 1'b0; m_si = '0;
        exp_vec = '0;

        test_reset();
        test_single_word();
        test_burst();
        test_flush();
        test_reset_mid_flush();
        test_random(500);
        test_gap0();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
